cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit CPU datapath (register file, ALU, data memory port).
- Accepts one instruction word on datain through a valid/ready handshake and latches it into an internal IR.
- Steps the datapath through DECODE/EXEC/MEM/WB, driving register-file, ALU and memory controls.
- Reports completion, illegal opcodes, memory timeouts and halt to the top-level CPU module.

Parameters:
- DATA_W, 16, instruction/immediate width.
- MEM_TIMEOUT, 15, maximum MEM-state cycles without mem_ack before abort (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- datain  in  16  instruction word: op[15:12], rd[11:8], rs[7:4], rt/imm[3:0].
- instr_valid  in  1  datain holds a valid instruction.
- instr_ready  out  1  sequencer can accept an instruction.
- mem_ack  in  1  memory completed the current read/write.
- rf_ra  out  4  register-file read address A (= rs).
- rf_rb  out  4  register-file read address B (= rt; = rd for ST).
- rf_wa  out  4  register-file write address (= rd).
- rf_we  out  1  register-file write enable.
- alu_op  out  3  0 pass, 1 add, 2 sub, 3 and, 4 or.
- alu_src_imm  out  1  ALU operand B comes from imm.
- imm  out  16  imm[3:0] sign-extended to 16 bits.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- wb_sel_mem  out  1  write-back data comes from memory.
- busy  out  1  state is neither IDLE nor HALTED.
- done  out  1  one-cycle pulse on instruction retire.
- illegal  out  1  pulses with done for an undefined opcode.
- mem_err  out  1  pulses with done on memory timeout.
- halted  out  1  high in HALTED.

Behaviour:
- States: IDLE, DECODE, EXEC, MEM, WB, HALTED.
- Outputs are Moore outputs, decoded from state, IR and the timeout counter.
- While rst=0, asynchronously: state=IDLE, IR=0, counter=0, ready_q=0, and every output is 0.
- ready_q sets on the first clock edge after rst releases.
- instr_ready = ready_q and state==IDLE.
- Accept occurs on a clock edge with instr_valid=1 and instr_ready=1: IR<=datain, next state DECODE.
- datain is ignored at all other times.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI (rd=rs+imm), 6 LD (rd=mem[rs+imm]), 7 ST (mem[rs+imm]=rd), F HALT; 8-E are illegal.
- rf_ra/rf_rb/rf_wa/imm are driven from IR in every non-IDLE state and are 0 in IDLE.
- DECODE (1 cycle):
  - HALT goes to HALTED.
  - Illegal opcodes go to WB with illegal=1 and no write.
  - All other opcodes go to EXEC.
- EXEC (1 cycle):
  - alu_op/alu_src_imm are valid.
  - ADDI/LD/ST use add with alu_src_imm=1.
  - NOP uses pass.
  - LD/ST go to MEM; all others go to WB.
- MEM:
  - LD holds mem_re=1; ST holds mem_we=1; alu_op stays at add.
  - The counter increments each MEM cycle.
  - A cycle with mem_ack=1 goes to WB.
  - After MEM_TIMEOUT cycles without mem_ack, go to WB with mem_err=1; the request lasts exactly MEM_TIMEOUT cycles.
  - mem_ack on the final timeout cycle counts as success.
  - mem_ack is ignored outside MEM. The counter clears on leaving MEM.
- WB (1 cycle):
  - done=1.
  - rf_we=1 for ADD/SUB/AND/OR/ADDI, and for LD without timeout. wb_sel_mem=1 for LD.
  - rf_we is suppressed when rd==0 (r0 is hardwired zero), and for NOP/ST/illegal/timeout.
  - Next state is IDLE.
- Latency (accept edge to done):
  - 3 cycles for ALU/NOP/illegal ops.
  - 4+k cycles for LD/ST, where k = MEM cycles - 1.
  - The next accept can occur 1 cycle after done.
- HALTED: halted=1, instr_ready=0; only reset exits.
- Reset mid-instruction aborts with no done pulse. Outputs clear immediately and asynchronously.

Test Plan:
- Reset release, instr_valid=1, datain=0x1123 (ADD r1=r2+r3):
  - instr_ready rises 1 cycle after release.
  - Accept occurs at T0, rf_ra=2, rf_rb=3, alu_op=1 at T2.
  - rf_we=1, rf_wa=1, done=1 at T3, instr_ready=1 at T4.
- 0x6120 (LD r1,[r2+0]) with mem_ack asserted on the 3rd MEM cycle:
  - mem_re high 3 cycles.
  - Then WB with rf_we=1, wb_sel_mem=1, done at accept+6.
- 0x7340 (ST) with mem_ack never asserted, MEM_TIMEOUT=15:
  - mem_we high exactly 15 cycles.
  - Then done=1, mem_err=1, rf_we=0.
  - Repeat with mem_ack on cycle 15: mem_err=0.
- 0x1023 (rd=0): done at T3 with rf_we=0. 0x9000: illegal=1 with done at T2, no writes.
- 0x5F1E (ADDI imm=0xE): imm=0xFFFE, alu_src_imm=1.
- 0xF000 then instr_valid held high: halted=1 and instr_ready stays 0 forever.
- Assert rst during MEM of an LD: all outputs 0 immediately, no done pulse, clean ADD executes after release.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_seq_ctrl                                                    |
// | Brief    : Multi-cycle DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cpu_seq_ctrl #(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              mem_ack,
  output logic [3:0]        rf_ra,
  output logic [3:0]        rf_rb,
  output logic [3:0]        rf_wa,
  output logic              rf_we,
  output logic [2:0]        alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm,
  output logic              mem_re,
  output logic              mem_we,
  output logic              wb_sel_mem,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              mem_err,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_and  = 4'h3;
  localparam logic [3:0] c_op_or   = 4'h4;
  localparam logic [3:0] c_op_addi = 4'h5;
  localparam logic [3:0] c_op_ld   = 4'h6;
  localparam logic [3:0] c_op_st   = 4'h7;
  localparam logic [3:0] c_op_halt = 4'hF;

  localparam logic [2:0] c_alu_pass = 3'd0;
  localparam logic [2:0] c_alu_add  = 3'd1;
  localparam logic [2:0] c_alu_sub  = 3'd2;
  localparam logic [2:0] c_alu_and  = 3'd3;
  localparam logic [2:0] c_alu_or   = 3'd4;

  localparam logic [7:0] c_cnt_last = 8'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;
  logic [7:0]        r_cnt;
  logic              r_ready_q;
  logic              r_timeout;

  logic [3:0] w_op;
  logic [3:0] w_rd;
  logic [3:0] w_rs;
  logic [3:0] w_rt;
  logic       w_illegal_op;
  logic       w_is_mem;
  logic       w_uses_imm;
  logic       w_writes_rd;

  assign w_op = r_ir[15:12];
  assign w_rd = r_ir[11:8];
  assign w_rs = r_ir[7:4];
  assign w_rt = r_ir[3:0];

  assign w_illegal_op = (w_op >= 4'h8) && (w_op != c_op_halt);
  assign w_is_mem     = (w_op == c_op_ld) || (w_op == c_op_st);
  assign w_uses_imm   = (w_op == c_op_addi) || w_is_mem;
  // A timed-out load has no data to write back.
  assign w_writes_rd  = ((w_op >= c_op_add) && (w_op <= c_op_addi)) ||
                        ((w_op == c_op_ld) && !r_timeout);

  assign instr_ready = r_ready_q && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_ready_q <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ready_q <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            r_ir      <= datain;
            r_timeout <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_op == c_op_halt)
            r_state <= S_HALTED;
          else if (w_illegal_op)
            r_state <= S_WB;
          else
            r_state <= S_EXEC;
        end
        S_EXEC: r_state <= w_is_mem ? S_MEM : S_WB;
        S_MEM: begin
          // An ack on the last allowed cycle wins over the timeout.
          if (mem_ack) begin
            r_cnt   <= '0;
            r_state <= S_WB;
          end else if (r_cnt == c_cnt_last) begin
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_WB;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WB: begin
          r_timeout <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_ra       = '0;
    rf_rb       = '0;
    rf_wa       = '0;
    imm         = '0;
    rf_we       = 1'b0;
    alu_op      = c_alu_pass;
    alu_src_imm = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    wb_sel_mem  = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;
    busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
    halted      = (r_state == S_HALTED);

    if (r_state != S_IDLE) begin
      rf_ra = w_rs;
      rf_rb = (w_op == c_op_st) ? w_rd : w_rt;
      rf_wa = w_rd;
      imm   = {{(DATA_W-4){w_rt[3]}}, w_rt};
    end

    case (r_state)
      S_EXEC: begin
        alu_src_imm = w_uses_imm;
        case (w_op)
          c_op_nop:                   alu_op = c_alu_pass;
          c_op_add:                   alu_op = c_alu_add;
          c_op_sub:                   alu_op = c_alu_sub;
          c_op_and:                   alu_op = c_alu_and;
          c_op_or:                    alu_op = c_alu_or;
          c_op_addi, c_op_ld, c_op_st: alu_op = c_alu_add;
          default:                    alu_op = c_alu_pass;
        endcase
      end
      S_MEM: begin
        alu_op      = c_alu_add;
        alu_src_imm = 1'b1;
        mem_re      = (w_op == c_op_ld);
        mem_we      = (w_op == c_op_st);
      end
      S_WB: begin
        done       = 1'b1;
        illegal    = w_illegal_op;
        mem_err    = r_timeout;
        wb_sel_mem = (w_op == c_op_ld);
        rf_we      = w_writes_rd && (w_rd != 4'h0);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// Directed bench for cpu_seq_ctrl: table of single-instruction vectors plus
// hand-written memory, reset and halt sequences.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] datain = '0;
  logic        instr_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic        instr_ready;
  logic [3:0]  rf_ra, rf_rb, rf_wa;
  logic        rf_we;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic [15:0] imm;
  logic        mem_re, mem_we, wb_sel_mem, busy, done, illegal, mem_err, halted;

  int n_cmp = 0;
  int n_err = 0;

  cpu_seq_ctrl #(.DATA_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .datain(datain), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ack(mem_ack),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm),
    .mem_re(mem_re), .mem_we(mem_we), .wb_sel_mem(wb_sel_mem),
    .busy(busy), .done(done), .illegal(illegal), .mem_err(mem_err),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  ra, rb, wa;
    logic [2:0]  alu;
    logic        src;
    logic [15:0] imm;
    logic        we;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, instr_ready, rf_ra, rf_rb, rf_wa, rf_we, alu_op, alu_src_imm, imm,
            mem_re, mem_we, wb_sel_mem, busy, done, illegal, mem_err, halted};
  endfunction

  // Leaves us at a point where instr_ready is high, sampled away from posedge.
  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 64'(instr_ready), 64'd1);
  endtask

  task automatic accept(input logic [15:0] din, input bit hold_valid);
    wait_ready();
    datain      = din;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_valid) instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int got = -1;
    accept(v.din, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1)
        check("decode_fields", 64'({rf_ra, rf_rb, rf_wa, imm, busy}),
              64'({v.ra, v.rb, v.wa, v.imm, 1'b1}));
      if (n == 2 && v.lat == 3)
        check("exec_alu", 64'({alu_op, alu_src_imm, mem_re, mem_we}),
              64'({v.alu, v.src, 2'b00}));
      if (done) begin
        got = n;
        check("wb_outs", 64'({rf_we, rf_wa, illegal, mem_err, wb_sel_mem, mem_re, mem_we}),
              64'({v.we, v.wa, v.ill, 4'b0000}));
        break;
      end
    end
    check("latency", 64'(got), 64'(v.lat));
    @(negedge clk);
    check("after_done", 64'({instr_ready, done, busy}), 64'(3'b100));
  endtask

  task automatic run_mem(input logic [15:0] din, input int ack_at,
                         input logic [3:0] e_ra, input logic [3:0] e_rb, input logic [3:0] e_wa,
                         input int e_re, input int e_we, input int e_lat,
                         input logic e_rfwe, input logic e_sel, input logic e_err);
    int re_cnt = 0;
    int we_cnt = 0;
    int got = -1;
    accept(din, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if (n == 1)
        check("mem_fields", 64'({rf_ra, rf_rb, rf_wa}), 64'({e_ra, e_rb, e_wa}));
      if (n == 3)
        check("mem_alu", 64'({alu_op, alu_src_imm}), 64'({3'd1, 1'b1}));
      if (done) begin
        got = n;
        mem_ack = 1'b0;
        check("mem_wb", 64'({rf_we, wb_sel_mem, mem_err, rf_wa, illegal}),
              64'({e_rfwe, e_sel, e_err, e_wa, 1'b0}));
        break;
      end
      // An ack during EXEC must be ignored.
      mem_ack = (n == 2) ||
                ((mem_re || mem_we) && ack_at != 0 && (re_cnt + we_cnt) == ack_at);
    end
    mem_ack = 1'b0;
    check("mem_re_cycles", 64'(re_cnt), 64'(e_re));
    check("mem_we_cycles", 64'(we_cnt), 64'(e_we));
    check("mem_latency", 64'(got), 64'(e_lat));
    @(negedge clk);
  endtask

  initial begin
    //          din       ra    rb    wa    alu   src  imm        we    ill   lat
    vecs[0] = '{16'h1123, 4'h2, 4'h3, 4'h1, 3'd1, 1'b0, 16'h0003, 1'b1, 1'b0, 3};
    vecs[1] = '{16'h2456, 4'h5, 4'h6, 4'h4, 3'd2, 1'b0, 16'h0006, 1'b1, 1'b0, 3};
    vecs[2] = '{16'h37A9, 4'hA, 4'h9, 4'h7, 3'd3, 1'b0, 16'hFFF9, 1'b1, 1'b0, 3};
    vecs[3] = '{16'h4BCD, 4'hC, 4'hD, 4'hB, 3'd4, 1'b0, 16'hFFFD, 1'b1, 1'b0, 3};
    vecs[4] = '{16'h5F1E, 4'h1, 4'hE, 4'hF, 3'd1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 3};
    vecs[5] = '{16'h1023, 4'h2, 4'h3, 4'h0, 3'd1, 1'b0, 16'h0003, 1'b0, 1'b0, 3};
    vecs[6] = '{16'h0ABC, 4'hB, 4'hC, 4'hA, 3'd0, 1'b0, 16'hFFFC, 1'b0, 1'b0, 3};
    vecs[7] = '{16'h9000, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 2};
    vecs[8] = '{16'hE5A7, 4'hA, 4'h7, 4'h5, 3'd0, 1'b0, 16'h0007, 1'b0, 1'b1, 2};

    // Reset with a valid instruction already presented.
    datain      = 16'h1123;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b1;
    #1;
    check("ready_at_release", 64'(instr_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(instr_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    run_mem(16'h6120, 3,  4'h2, 4'h0, 4'h1, 3,  0,  6,  1'b1, 1'b1, 1'b0);
    run_mem(16'h7340, 0,  4'h4, 4'h3, 4'h3, 0,  15, 18, 1'b0, 1'b0, 1'b1);
    run_mem(16'h7340, 15, 4'h4, 4'h3, 4'h3, 0,  15, 18, 1'b0, 1'b0, 1'b0);
    run_mem(16'h6120, 0,  4'h2, 4'h0, 4'h1, 15, 0,  18, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a load's MEM phase.
    accept(16'h6120, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_ld_mem_re", 64'({mem_re, busy}), 64'(2'b11));
    #2 rst = 1'b0;
    #1;
    check("async_reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    check("reset_hold_outs", all_outs(), 64'd0);
    rst = 1'b1;
    run_vec(vecs[0]);

    // HALT with instr_valid held high afterwards.
    accept(16'hF000, 1'b1);
    @(negedge clk);
    check("halt_decode", 64'({halted, busy}), 64'(2'b01));
    @(negedge clk);
    check("halted_state", 64'({halted, instr_ready, busy, done}), 64'(4'b1000));
    repeat (20) @(negedge clk);
    check("halted_stays", 64'({halted, instr_ready, busy, done}), 64'(4'b1000));
    instr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
